// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel-request stream (req_*) plus the aligned video/sync side.
interface vga_timing_if #(
    parameter int COORD_W = 10,
    parameter int FRAME_W = 16
);
    logic               req_valid;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic               h_sync;
    logic               v_sync;
    logic               disp_ena;
    logic [COORD_W-1:0] column;
    logic [COORD_W-1:0] row;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        output req_valid, req_x, req_y, h_sync, v_sync, disp_ena,
               column, row, line_start, frame_start, frame_count
    );
    modport slave (
        input  req_valid, req_x, req_y, h_sync, v_sync, disp_ena,
               column, row, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: req_* stream leads the video/sync outputs by
// LATENCY enabled cycles so an external pixel pipeline of that depth lines up exactly.
module vga_timing_gen #(
    parameter int   H_PIXELS = 640,
    parameter int   H_FP     = 16,
    parameter int   H_PULSE  = 96,
    parameter int   H_BP     = 48,
    parameter int   V_PIXELS = 480,
    parameter int   V_FP     = 10,
    parameter int   V_PULSE  = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   COORD_W  = 10,
    parameter int   LATENCY  = 2,
    parameter int   FRAME_W  = 16
) (
    input  logic         pixel_clk,
    input  logic         reset,
    input  logic         enable,
    vga_timing_if.master vid
);
    localparam int H_PERIOD = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int V_PERIOD = V_PIXELS + V_FP + V_PULSE + V_BP;
    localparam int HC_W     = $clog2(H_PERIOD);
    localparam int VC_W     = $clog2(V_PERIOD);

    // Region boundaries carry one spare bit so a zero-length back porch cannot wrap them.
    localparam logic [HC_W:0]   H_ACT_END  = (HC_W+1)'(H_PIXELS);
    localparam logic [HC_W:0]   H_FP_END   = (HC_W+1)'(H_PIXELS + H_FP);
    localparam logic [HC_W:0]   H_SYNC_END = (HC_W+1)'(H_PIXELS + H_FP + H_PULSE);
    localparam logic [VC_W:0]   V_ACT_END  = (VC_W+1)'(V_PIXELS);
    localparam logic [VC_W:0]   V_FP_END   = (VC_W+1)'(V_PIXELS + V_FP);
    localparam logic [VC_W:0]   V_SYNC_END = (VC_W+1)'(V_PIXELS + V_FP + V_PULSE);
    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_PERIOD - 1);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_PERIOD - 1);

    if (((2 ** COORD_W) < H_PIXELS) || ((2 ** COORD_W) < V_PIXELS)) begin : g_coord_chk
        $error("vga_timing_gen: COORD_W too narrow for H_PIXELS/V_PIXELS");
    end
    if ((LATENCY < 1) || (LATENCY > 8)) begin : g_lat_chk
        $error("vga_timing_gen: LATENCY must be 1..8");
    end

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_t;

    typedef struct packed {
        logic               vld;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               hs;
        logic               vs;
        logic               ls;
        logic               fs;
    } stage_t;

    function automatic region_t h_region(input logic [HC_W-1:0] h);
        if ({1'b0, h} < H_ACT_END)       return ACTIVE;
        else if ({1'b0, h} < H_FP_END)   return FP;
        else if ({1'b0, h} < H_SYNC_END) return SYNC;
        else                             return BP;
    endfunction

    function automatic region_t v_region(input logic [VC_W-1:0] v);
        if ({1'b0, v} < V_ACT_END)       return ACTIVE;
        else if ({1'b0, v} < V_FP_END)   return FP;
        else if ({1'b0, v} < V_SYNC_END) return SYNC;
        else                             return BP;
    endfunction

    logic [HC_W-1:0]    h_cnt, h_cnt_nxt;
    logic [VC_W-1:0]    v_cnt, v_cnt_nxt;
    region_t            h_state, h_state_nxt, v_state, v_state_nxt;
    logic               h_act, h_sy, v_act, v_sy;
    stage_t             dec;
    stage_t             st_p0;
    stage_t             dly_pn [1:LATENCY];
    logic [FRAME_W-1:0] frame_cnt;

    always_comb begin
        h_cnt_nxt = (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
        v_cnt_nxt = v_cnt;
        if (h_cnt == H_LAST) v_cnt_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_state <= ACTIVE;
            v_state <= ACTIVE;
        end else if (enable) begin
            h_cnt   <= h_cnt_nxt;
            v_cnt   <= v_cnt_nxt;
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
        end
    end

    // The region follows the counter, so it advances ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
    always_comb begin
        h_state_nxt = h_region(h_cnt_nxt);
        v_state_nxt = v_region(v_cnt_nxt);
    end

    always_comb begin
        h_act = (h_state == ACTIVE);
        h_sy  = (h_state == SYNC);
        v_act = (v_state == ACTIVE);
        v_sy  = (v_state == SYNC);
    end

    always_comb begin
        dec     = '0;
        dec.vld = h_act && v_act;
        dec.x   = dec.vld ? COORD_W'(h_cnt) : '0;
        dec.y   = dec.vld ? COORD_W'(v_cnt) : '0;
        dec.hs  = h_sy;
        dec.vs  = v_sy;
        dec.ls  = (h_cnt == '0);
        dec.fs  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage 0 (request side) and LATENCY delay stages (video side); all hold when disabled.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            st_p0 <= '0;
            for (int i = 1; i <= LATENCY; i++) dly_pn[i] <= '0;
        end else if (enable) begin
            st_p0     <= dec;
            dly_pn[1] <= st_p0;
            for (int i = 2; i <= LATENCY; i++) dly_pn[i] <= dly_pn[i-1];
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset)                              frame_cnt <= '0;
        else if (enable && dly_pn[LATENCY].fs) frame_cnt <= frame_cnt + 1'b1;
    end

    assign vid.req_valid   = st_p0.vld;
    assign vid.req_x       = st_p0.x;
    assign vid.req_y       = st_p0.y;
    assign vid.disp_ena    = dly_pn[LATENCY].vld;
    assign vid.column      = dly_pn[LATENCY].x;
    assign vid.row         = dly_pn[LATENCY].y;
    assign vid.h_sync      = dly_pn[LATENCY].hs ? H_POL : ~H_POL;
    assign vid.v_sync      = dly_pn[LATENCY].vs ? V_POL : ~V_POL;
    assign vid.line_start  = dly_pn[LATENCY].ls;
    assign vid.frame_start = dly_pn[LATENCY].fs;
    assign vid.frame_count = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: one 640x480 instance plus three small-raster instances (LATENCY 5/1/8).
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1, en_d = 1'b0;
    logic rst_s = 1'b1, en_s = 1'b0;

    vga_timing_if #(.COORD_W(10), .FRAME_W(16)) if_d();
    vga_timing_if #(.COORD_W(3),  .FRAME_W(2))  if_a();
    vga_timing_if #(.COORD_W(4),  .FRAME_W(2))  if_b();
    vga_timing_if #(.COORD_W(3),  .FRAME_W(16)) if_c();

    vga_timing_gen u_def (.pixel_clk(clk), .reset(rst_d), .enable(en_d), .vid(if_d));

    vga_timing_gen #(.H_PIXELS(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
                     .V_PIXELS(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
                     .COORD_W(3), .LATENCY(5), .FRAME_W(2))
        u_a (.pixel_clk(clk), .reset(rst_s), .enable(en_s), .vid(if_a));

    vga_timing_gen #(.H_PIXELS(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
                     .V_PIXELS(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1),
                     .COORD_W(4), .LATENCY(1), .FRAME_W(2))
        u_b (.pixel_clk(clk), .reset(rst_s), .enable(en_s), .vid(if_b));

    vga_timing_gen #(.H_PIXELS(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
                     .V_PIXELS(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
                     .COORD_W(3), .LATENCY(8), .FRAME_W(16))
        u_c (.pixel_clk(clk), .reset(rst_s), .enable(en_s), .vid(if_c));

    typedef struct packed {
        logic [7:0]  rv, rx, ry, hs, vs, de, col, row, ls, fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct packed {
        logic [7:0] vld, x, y, hs, vs, ls, fs;
    } pos_t;

    int checks = 0;
    int passes = 0;
    int n;
    int fc_exp [3];
    int lat_s  [3] = '{5, 1, 8};
    bit pol_s  [3] = '{1'b0, 1'b1, 1'b0};
    int fcmask [3] = '{3, 3, 65535};

    // Small raster: line of 8 clocks (sync at h 5..6), frame of 6 lines (sync on line 4).
    function automatic pos_t pos_small(input int p, input bit pol);
        pos_t r;
        int h, v;
        r = '0;
        if (p < 0) begin
            r.hs = {7'b0, ~pol};
            r.vs = {7'b0, ~pol};
        end else begin
            h = p % 8;
            v = (p / 8) % 6;
            r.vld = 8'((h < 4) && (v < 3));
            r.x   = (h < 4 && v < 3) ? 8'(h) : 8'd0;
            r.y   = (h < 4 && v < 3) ? 8'(v) : 8'd0;
            r.hs  = {7'b0, (h >= 5 && h <= 6) ? pol : ~pol};
            r.vs  = {7'b0, (v == 4) ? pol : ~pol};
            r.ls  = 8'(h == 0);
            r.fs  = 8'(h == 0 && v == 0);
        end
        return r;
    endfunction

    function automatic obs_t exp_small(input int d);
        obs_t e;
        pos_t rq, vd;
        rq = pos_small(n - 1, pol_s[d]);
        vd = pos_small(n - 1 - lat_s[d], pol_s[d]);
        e.rv = rq.vld; e.rx = rq.x; e.ry = rq.y;
        e.hs = vd.hs;  e.vs = vd.vs; e.de = vd.vld;
        e.col = vd.x;  e.row = vd.y; e.ls = vd.ls; e.fs = vd.fs;
        e.fc = 16'(fc_exp[d]);
        return e;
    endfunction

    function automatic obs_t sample_small(input int d);
        obs_t o;
        o = '0;
        case (d)
            0: begin
                o.rv = 8'(if_a.req_valid); o.rx = 8'(if_a.req_x); o.ry = 8'(if_a.req_y);
                o.hs = 8'(if_a.h_sync); o.vs = 8'(if_a.v_sync); o.de = 8'(if_a.disp_ena);
                o.col = 8'(if_a.column); o.row = 8'(if_a.row); o.ls = 8'(if_a.line_start);
                o.fs = 8'(if_a.frame_start); o.fc = 16'(if_a.frame_count);
            end
            1: begin
                o.rv = 8'(if_b.req_valid); o.rx = 8'(if_b.req_x); o.ry = 8'(if_b.req_y);
                o.hs = 8'(if_b.h_sync); o.vs = 8'(if_b.v_sync); o.de = 8'(if_b.disp_ena);
                o.col = 8'(if_b.column); o.row = 8'(if_b.row); o.ls = 8'(if_b.line_start);
                o.fs = 8'(if_b.frame_start); o.fc = 16'(if_b.frame_count);
            end
            default: begin
                o.rv = 8'(if_c.req_valid); o.rx = 8'(if_c.req_x); o.ry = 8'(if_c.req_y);
                o.hs = 8'(if_c.h_sync); o.vs = 8'(if_c.v_sync); o.de = 8'(if_c.disp_ena);
                o.col = 8'(if_c.column); o.row = 8'(if_c.row); o.ls = 8'(if_c.line_start);
                o.fs = 8'(if_c.frame_start); o.fc = if_c.frame_count;
            end
        endcase
        return o;
    endfunction

    task automatic do_reset_small;
        @(negedge clk); rst_s = 1'b1; en_s = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk); rst_s = 1'b0; en_s = 1'b0;
        n = 0;
        for (int d = 0; d < 3; d++) fc_exp[d] = 0;
    endtask

    // One clock for the small instances; frame_count model counts enabled edges that see frame_start.
    task automatic tick_small(input bit en);
        pos_t vd;
        @(negedge clk);
        en_s = en;
        if (en) begin
            for (int d = 0; d < 3; d++) begin
                vd = pos_small(n - 1 - lat_s[d], pol_s[d]);
                if (vd.fs[0]) fc_exp[d] = (fc_exp[d] + 1) & fcmask[d];
            end
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_d = 1'b1; en_d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if_d.req_valid, if_d.disp_ena} !== 2'b00) $display("FAIL reset_valid got=%b exp=00", {if_d.req_valid, if_d.disp_ena});
        else passes++;
        checks++;
        if ({if_d.h_sync, if_d.v_sync} !== 2'b11) $display("FAIL reset_sync got=%b exp=11", {if_d.h_sync, if_d.v_sync});
        else passes++;
        checks++;
        if ({if_d.req_x, if_d.req_y, if_d.column, if_d.row} !== 40'd0) $display("FAIL reset_coords got=%h exp=0", {if_d.req_x, if_d.req_y, if_d.column, if_d.row});
        else passes++;
        checks++;
        if ({if_d.line_start, if_d.frame_start, if_d.frame_count} !== 18'd0) $display("FAIL reset_pulses got=%h exp=0", {if_d.line_start, if_d.frame_start, if_d.frame_count});
        else passes++;
    endtask

    task automatic test_first_line;
        @(negedge clk); rst_d = 1'b0; en_d = 1'b1;
        for (int k = 1; k <= 645; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                checks++;
                if ({if_d.req_valid, if_d.req_x, if_d.req_y, if_d.disp_ena} !== {1'b1, 10'd0, 10'd0, 1'b0})
                    $display("FAIL first_req got=%h exp=%h", {if_d.req_valid, if_d.req_x, if_d.req_y, if_d.disp_ena}, {1'b1, 10'd0, 10'd0, 1'b0});
                else passes++;
            end
            if (k == 2) begin
                checks++;
                if ({if_d.disp_ena, if_d.frame_start} !== 2'b00) $display("FAIL early_video got=%b exp=00", {if_d.disp_ena, if_d.frame_start});
                else passes++;
            end
            if (k == 3) begin
                checks++;
                if ({if_d.disp_ena, if_d.column, if_d.row, if_d.frame_start, if_d.line_start, if_d.frame_count} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'd0})
                    $display("FAIL first_pixel got=%h exp=%h", {if_d.disp_ena, if_d.column, if_d.row, if_d.frame_start, if_d.line_start, if_d.frame_count}, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'd0});
                else passes++;
            end
            if (k == 4) begin
                checks++;
                if ({if_d.disp_ena, if_d.column, if_d.frame_start, if_d.frame_count} !== {1'b1, 10'd1, 1'b0, 16'd1})
                    $display("FAIL second_pixel got=%h exp=%h", {if_d.disp_ena, if_d.column, if_d.frame_start, if_d.frame_count}, {1'b1, 10'd1, 1'b0, 16'd1});
                else passes++;
            end
            if (k == 642) begin
                checks++;
                if ({if_d.disp_ena, if_d.column, if_d.req_valid, if_d.req_x} !== {1'b1, 10'd639, 1'b0, 10'd0})
                    $display("FAIL last_active got=%h exp=%h", {if_d.disp_ena, if_d.column, if_d.req_valid, if_d.req_x}, {1'b1, 10'd639, 1'b0, 10'd0});
                else passes++;
            end
            if (k == 643) begin
                checks++;
                if ({if_d.disp_ena, if_d.column, if_d.row, if_d.h_sync} !== {1'b0, 10'd0, 10'd0, 1'b1})
                    $display("FAIL after_active got=%h exp=%h", {if_d.disp_ena, if_d.column, if_d.row, if_d.h_sync}, {1'b0, 10'd0, 10'd0, 1'b1});
                else passes++;
            end
        end
    endtask

    task automatic test_hsync;
        int first_ls, second_ls, fall, low_cnt, vs_low;
        logic prev_hs;
        first_ls = -1; second_ls = -1; fall = -1; low_cnt = 0; vs_low = 0; prev_hs = 1'b1;
        @(negedge clk); rst_d = 1'b1;
        @(posedge clk); @(negedge clk); rst_d = 1'b0; en_d = 1'b1;
        for (int k = 1; k <= 1700; k++) begin
            @(posedge clk); #1;
            if (if_d.line_start === 1'b1) begin
                if (first_ls < 0) first_ls = k;
                else if (second_ls < 0) second_ls = k;
            end
            if (if_d.h_sync === 1'b0 && first_ls >= 0 && second_ls < 0) low_cnt++;
            if (prev_hs === 1'b1 && if_d.h_sync === 1'b0 && fall < 0) fall = k;
            if (if_d.v_sync !== 1'b1) vs_low++;
            prev_hs = if_d.h_sync;
            if (k == 803) begin
                checks++;
                if ({if_d.line_start, if_d.disp_ena, if_d.column, if_d.row} !== {1'b1, 1'b1, 10'd0, 10'd1})
                    $display("FAIL line1_start got=%h exp=%h", {if_d.line_start, if_d.disp_ena, if_d.column, if_d.row}, {1'b1, 1'b1, 10'd0, 10'd1});
                else passes++;
            end
        end
        checks++;
        if (first_ls !== 3) $display("FAIL first_line_start got=%0d exp=3", first_ls); else passes++;
        checks++;
        if (fall - first_ls !== 656) $display("FAIL hsync_offset got=%0d exp=656", fall - first_ls); else passes++;
        checks++;
        if (low_cnt !== 96) $display("FAIL hsync_width got=%0d exp=96", low_cnt); else passes++;
        checks++;
        if (second_ls - first_ls !== 800) $display("FAIL line_period got=%0d exp=800", second_ls - first_ls); else passes++;
        checks++;
        if (vs_low !== 0) $display("FAIL vsync_early got=%0d exp=0", vs_low); else passes++;
    endtask

    task automatic test_small_reset;
        obs_t got, ex;
        @(negedge clk); rst_s = 1'b1; en_s = 1'b1;
        n = 0;
        for (int d = 0; d < 3; d++) fc_exp[d] = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                got = sample_small(d); ex = exp_small(d);
                checks++;
                if (got !== ex) $display("FAIL small_reset dut%0d got=%h exp=%h", d, got, ex);
                else passes++;
            end
        end
    endtask

    task automatic test_latency_sweep;
        obs_t got, ex;
        do_reset_small();
        for (int k = 0; k < 3 * 48 + 8; k++) begin
            tick_small(1'b1);
            for (int d = 0; d < 3; d++) begin
                got = sample_small(d); ex = exp_small(d);
                checks++;
                if (got !== ex) $display("FAIL latency dut%0d n=%0d got=%h exp=%h", d, n, got, ex);
                else passes++;
            end
        end
    endtask

    task automatic test_small_periods;
        int a_first, a_cnt, b_first, b_cnt;
        a_first = -1; a_cnt = 0; b_first = -1; b_cnt = 0;
        do_reset_small();
        for (int k = 1; k <= 60; k++) begin
            tick_small(1'b1);
            if (if_a.v_sync === 1'b0) begin a_cnt++; if (a_first < 0) a_first = k; end
            if (if_b.v_sync === 1'b1) begin b_cnt++; if (b_first < 0) b_first = k; end
            if (k == 6 || k == 7) begin
                checks++;
                if (if_b.h_sync !== ((k == 7) ? 1'b1 : 1'b0)) $display("FAIL hpol_level k=%0d got=%b", k, if_b.h_sync);
                else passes++;
            end
        end
        checks++;
        if (a_first !== 38) $display("FAIL vsync_start got=%0d exp=38", a_first); else passes++;
        checks++;
        if (a_cnt !== 8) $display("FAIL vsync_width got=%0d exp=8", a_cnt); else passes++;
        checks++;
        if (b_first !== 34) $display("FAIL vpol_start got=%0d exp=34", b_first); else passes++;
        checks++;
        if (b_cnt !== 8) $display("FAIL vpol_width got=%0d exp=8", b_cnt); else passes++;
    endtask

    task automatic test_enable_gaps;
        obs_t got, ex;
        do_reset_small();
        for (int k = 0; k < 250; k++) begin
            tick_small(1'($urandom_range(0, 1)));
            for (int d = 0; d < 3; d++) begin
                got = sample_small(d); ex = exp_small(d);
                checks++;
                if (got !== ex) $display("FAIL enable_gap dut%0d n=%0d got=%h exp=%h", d, n, got, ex);
                else passes++;
            end
        end
        en_s = 1'b0;
    endtask

    task automatic test_frame_wrap;
        int idx, prev;
        idx = 0; prev = -1;
        do_reset_small();
        for (int k = 1; k <= 200; k++) begin
            tick_small(1'b1);
            if (if_a.frame_start === 1'b1) begin
                checks++;
                if (if_a.frame_count !== 2'(idx % 4)) $display("FAIL frame_count pulse=%0d got=%0d exp=%0d", idx, if_a.frame_count, idx % 4);
                else passes++;
                if (prev >= 0) begin
                    checks++;
                    if (k - prev !== 48) $display("FAIL frame_period got=%0d exp=48", k - prev);
                    else passes++;
                end
                prev = k;
                idx++;
            end
        end
        checks++;
        if (idx !== 5) $display("FAIL frame_pulses got=%0d exp=5", idx); else passes++;
    endtask

    task automatic test_mid_reset;
        obs_t got, ex;
        do_reset_small();
        for (int k = 0; k < 71; k++) tick_small(1'b1);
        checks++;
        if ({if_a.frame_count, if_a.disp_ena, if_a.column, if_a.row} !== {2'd2, 1'b1, 3'd1, 3'd2})
            $display("FAIL pre_reset got=%h exp=%h", {if_a.frame_count, if_a.disp_ena, if_a.column, if_a.row}, {2'd2, 1'b1, 3'd1, 3'd2});
        else passes++;
        @(negedge clk); rst_s = 1'b1; en_s = 1'b1;
        @(posedge clk); #1;
        n = 0;
        for (int d = 0; d < 3; d++) fc_exp[d] = 0;
        for (int d = 0; d < 3; d++) begin
            got = sample_small(d); ex = exp_small(d);
            checks++;
            if (got !== ex) $display("FAIL mid_reset dut%0d got=%h exp=%h", d, got, ex);
            else passes++;
        end
        @(negedge clk); rst_s = 1'b0; en_s = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick_small(1'b1);
            for (int d = 0; d < 3; d++) begin
                got = sample_small(d); ex = exp_small(d);
                checks++;
                if (got !== ex) $display("FAIL restart dut%0d n=%0d got=%h exp=%h", d, n, got, ex);
                else passes++;
            end
            if (n == 6) begin
                checks++;
                if ({if_a.disp_ena, if_a.frame_start, if_a.line_start} !== 3'b111)
                    $display("FAIL restart_first got=%b exp=111", {if_a.disp_ena, if_a.frame_start, if_a.line_start});
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_hsync();
        test_small_reset();
        test_latency_sweep();
        test_small_periods();
        test_enable_gaps();
        test_frame_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
